// File: rtl/dtcore32_rf_wr_sched.sv
// dtcore32_rf_wr_sched: write-port arbiter and load scoreboard for the 2R/1W regfile.
// Optional same-cycle pop bypass of the stall check: DTCORE32_RF_BYPASS_EN.
module dtcore32_rf_wr_sched #(
  parameter int LD_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        iss_valid_i,
  input  logic [4:0]  iss_rs1_addr_i,
  input  logic [4:0]  iss_rs2_addr_i,
  input  logic [4:0]  iss_rd_addr_i,
  input  logic        iss_is_load_i,
  output logic        iss_stall_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_hold_o,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [4:0]  ld_rd_addr_i,
  input  logic [31:0] ld_data_i,
  output logic [4:0]  rf_rd_addr_o,
  output logic [31:0] rf_wr_data_o,
  output logic [31:0] pending_o
);

  localparam int AW = $clog2(LD_FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_ent_t;

  ld_ent_t       fifo_q [LD_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   cnt_q;
  logic [CW-1:0] starve_q;
  logic          hold_q;
  logic [31:0]   pend_q;

  ld_ent_t     head;
  logic        empty;
  logic        full;
  logic        wb_fire;
  logic        pop;
  logic        push;
  logic        iss_fire;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [31:0] pend_chk;

  assign head  = fifo_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(LD_FIFO_DEPTH));

  // Pipeline writeback owns the port unless held off; loads fill the gaps.
  always_comb begin
    wb_fire      = ~rst_i & wb_valid_i & ~hold_q;
    pop          = ~rst_i & ~empty & ~wb_fire;
    ld_ready_o   = ~rst_i & ~full;
    push         = ld_valid_i & ld_ready_o;
    rf_rd_addr_o = '0;
    rf_wr_data_o = '0;
    if (wb_fire) begin
      rf_rd_addr_o = wb_rd_addr_i;
      rf_wr_data_o = wb_data_i;
    end else if (pop) begin
      rf_rd_addr_o = head.rd;
      rf_wr_data_o = head.data;
    end
  end

  // Hazard check against outstanding load destinations.
  always_comb begin
    clr_vec = pop ? (32'(1) << head.rd) : '0;
`ifdef DTCORE32_RF_BYPASS_EN
    pend_chk = pend_q & ~clr_vec;
`else
    pend_chk = pend_q;
`endif
    iss_stall_o = ~rst_i & iss_valid_i &
                  (pend_chk[iss_rs1_addr_i] |
                   pend_chk[iss_rs2_addr_i] |
                   pend_chk[iss_rd_addr_i]);
    iss_fire = iss_valid_i & ~iss_stall_o;
    set_vec  = '0;
    if (iss_fire && iss_is_load_i && iss_rd_addr_i != 5'd0)
      set_vec = 32'(1) << iss_rd_addr_i;
  end

  // Load-return buffer storage; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (push)
      fifo_q[wr_ptr_q] <= '{rd: ld_rd_addr_i, data: ld_data_i};
  end

  // Pointers, scoreboard, and starvation tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      hold_q   <= 1'b0;
      pend_q   <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q  <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      pend_q <= ((pend_q & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
      if (empty || pop)
        starve_q <= '0;
      else
        starve_q <= starve_q + 1'b1;
      if (pop)
        hold_q <= 1'b0;
      else if (!empty && starve_q == CW'(STARVE_LIMIT - 1))
        hold_q <= 1'b1;
    end
  end

  assign wb_hold_o = hold_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_dtcore32_rf_wr_sched.sv
// tb_dtcore32_rf_wr_sched: directed and random checks against a queue-based model.
// Define DTCORE32_RF_BYPASS_EN to check the bypass build.
module tb_dtcore32_rf_wr_sched;

  localparam int D  = 4;
  localparam int SL = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        iss_valid_i;
  logic [4:0]  iss_rs1_addr_i;
  logic [4:0]  iss_rs2_addr_i;
  logic [4:0]  iss_rd_addr_i;
  logic        iss_is_load_i;
  logic        iss_stall_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_hold_o;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [4:0]  ld_rd_addr_i;
  logic [31:0] ld_data_i;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_wr_data_o;
  logic [31:0] pending_o;

  always #5 clk = ~clk;

  dtcore32_rf_wr_sched #(
    .LD_FIFO_DEPTH(D),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .iss_valid_i   (iss_valid_i),
    .iss_rs1_addr_i(iss_rs1_addr_i),
    .iss_rs2_addr_i(iss_rs2_addr_i),
    .iss_rd_addr_i (iss_rd_addr_i),
    .iss_is_load_i (iss_is_load_i),
    .iss_stall_o   (iss_stall_o),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_addr_i  (wb_rd_addr_i),
    .wb_data_i     (wb_data_i),
    .wb_hold_o     (wb_hold_o),
    .ld_valid_i    (ld_valid_i),
    .ld_ready_o    (ld_ready_o),
    .ld_rd_addr_i  (ld_rd_addr_i),
    .ld_data_i     (ld_data_i),
    .rf_rd_addr_o  (rf_rd_addr_o),
    .rf_wr_data_o  (rf_wr_data_o),
    .pending_o     (pending_o)
  );

  int ncmp = 0;
  int nerr = 0;

  logic [36:0] q[$];
  bit   [31:0] m_pend;
  int          m_wait;
  bit          m_hold;
  bit          m_ok = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iss_valid_i    = 0;
    iss_rs1_addr_i = 0;
    iss_rs2_addr_i = 0;
    iss_rd_addr_i  = 0;
    iss_is_load_i  = 0;
    wb_valid_i     = 0;
    wb_rd_addr_i   = 0;
    wb_data_i      = 0;
    ld_valid_i     = 0;
    ld_rd_addr_i   = 0;
    ld_data_i      = 0;
  endtask

  task automatic settle();
    #1;
  endtask

  // Check this cycle's outputs against the model, then advance both.
  task automatic cycle();
    bit          wbf;
    bit          mpop;
    bit          e_stall;
    bit          e_ready;
    bit          was_ne;
    logic [4:0]  hrd;
    logic [31:0] hdat;
    logic [4:0]  e_addr;
    bit   [31:0] pv;
    #2;
    wbf  = !rst_i && wb_valid_i && !m_hold;
    mpop = !rst_i && q.size() > 0 && !wbf;
    hrd  = q.size() > 0 ? q[0][36:32] : 5'd0;
    hdat = q.size() > 0 ? q[0][31:0] : 32'd0;
    pv   = m_pend;
`ifdef DTCORE32_RF_BYPASS_EN
    if (mpop) pv[hrd] = 1'b0;
`endif
    e_stall = !rst_i && iss_valid_i &&
              (pv[iss_rs1_addr_i] || pv[iss_rs2_addr_i] || pv[iss_rd_addr_i]);
    e_ready = !rst_i && q.size() < D;
    e_addr  = rst_i ? 5'd0 : wbf ? wb_rd_addr_i : mpop ? hrd : 5'd0;
    chk("stall", 32'(iss_stall_o), 32'(e_stall));
    chk("ready", 32'(ld_ready_o), 32'(e_ready));
    chk("rf_addr", 32'(rf_rd_addr_o), 32'(e_addr));
    if (rst_i)
      chk("rf_data_rst", rf_wr_data_o, 32'd0);
    else if (wbf)
      chk("rf_data_wb", rf_wr_data_o, wb_data_i);
    else if (mpop)
      chk("rf_data_ld", rf_wr_data_o, hdat);
    if (m_ok) begin
      chk("pending", pending_o, m_pend);
      chk("hold", 32'(wb_hold_o), 32'(m_hold));
    end
    if (rst_i) begin
      q.delete();
      m_pend = 0;
      m_wait = 0;
      m_hold = 0;
      m_ok   = 1;
    end else begin
      was_ne = q.size() > 0;
      if (mpop) begin
        void'(q.pop_front());
        if (hrd != 0) m_pend[hrd] = 1'b0;
      end
      if (ld_valid_i && e_ready)
        q.push_back({ld_rd_addr_i, ld_data_i});
      if (iss_valid_i && !e_stall && iss_is_load_i && iss_rd_addr_i != 0)
        m_pend[iss_rd_addr_i] = 1'b1;
      if (mpop || !was_ne) m_wait = 0;
      else m_wait++;
      if (mpop) m_hold = 0;
      else if (m_wait == SL) m_hold = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    idle();
    rst_i = 1;
    @(posedge clk);
    #1;
    cycle();
    rst_i = 0;
    chk("rst_pend", pending_o, 32'd0);
    chk("rst_hold", 32'(wb_hold_o), 32'd0);

    // RAW on an outstanding load
    iss_valid_i = 1; iss_rd_addr_i = 5; iss_is_load_i = 1;
    cycle();
    iss_rs1_addr_i = 5; iss_rd_addr_i = 6; iss_is_load_i = 0;
    settle();
    chk("raw_pend", pending_o, 32'h20);
    chk("raw_stall", 32'(iss_stall_o), 32'd1);
    cycle();
    cycle();
    ld_valid_i = 1; ld_rd_addr_i = 5; ld_data_i = 32'h55;
    cycle();
    ld_valid_i = 0;
    settle();
    chk("raw_pop_addr", 32'(rf_rd_addr_o), 32'd5);
`ifdef DTCORE32_RF_BYPASS_EN
    chk("raw_pop_stall", 32'(iss_stall_o), 32'd0);
`else
    chk("raw_pop_stall", 32'(iss_stall_o), 32'd1);
`endif
    cycle();
    settle();
    chk("raw_after_stall", 32'(iss_stall_o), 32'd0);
    cycle();
    idle();

    // Writeback wins over a same-cycle load return
    ld_valid_i = 1; ld_rd_addr_i = 7; ld_data_i = 32'hDEADBEEF;
    wb_valid_i = 1; wb_rd_addr_i = 3; wb_data_i = 32'h11;
    settle();
    chk("arb_wb_addr", 32'(rf_rd_addr_o), 32'd3);
    chk("arb_wb_data", rf_wr_data_o, 32'h11);
    cycle();
    idle();
    settle();
    chk("arb_ld_addr", 32'(rf_rd_addr_o), 32'd7);
    chk("arb_ld_data", rf_wr_data_o, 32'hDEADBEEF);
    cycle();

    // Fill the buffer with writeback hogging the port, then starve
    wb_valid_i = 1; wb_rd_addr_i = 1; wb_data_i = 32'hA5A5;
    for (int i = 0; i < 4; i++) begin
      ld_valid_i = 1; ld_rd_addr_i = 5'(10 + i); ld_data_i = 32'(i + 100);
      cycle();
    end
    ld_valid_i = 0;
    settle();
    chk("full_ready", 32'(ld_ready_o), 32'd0);
    waited = 0;
    while (!wb_hold_o && waited < 20) begin
      cycle();
      waited++;
    end
    chk("starve_hold", 32'(wb_hold_o), 32'd1);
    chk("starve_wait", 32'(waited), 32'd5);
    settle();
    chk("starve_pop_addr", 32'(rf_rd_addr_o), 32'd10);
    cycle();
    chk("starve_clear", 32'(wb_hold_o), 32'd0);
    idle();
    for (int i = 0; i < 4; i++) cycle();

    // Load return to x0
    ld_valid_i = 1; ld_rd_addr_i = 0; ld_data_i = 32'h77;
    cycle();
    idle();
    settle();
    chk("x0_addr", 32'(rf_rd_addr_o), 32'd0);
    cycle();
    chk("x0_pend", pending_o, 32'd0);

    // WAW on x9
    iss_valid_i = 1; iss_rd_addr_i = 9; iss_is_load_i = 1;
    cycle();
    settle();
    chk("waw_stall", 32'(iss_stall_o), 32'd1);
    cycle();
    ld_valid_i = 1; ld_rd_addr_i = 9; ld_data_i = 32'h99;
    cycle();
    ld_valid_i = 0;
    cycle();
    cycle();
    idle();
    ld_valid_i = 1; ld_rd_addr_i = 9; ld_data_i = 32'h98;
    cycle();
    idle();
    cycle();
    cycle();
    chk("waw_pend", pending_o, 32'd0);

    // Reset with buffered loads
    iss_valid_i = 1; iss_rd_addr_i = 8; iss_is_load_i = 1;
    cycle();
    iss_rd_addr_i = 9;
    cycle();
    idle();
    wb_valid_i = 1; wb_rd_addr_i = 2; wb_data_i = 32'h22;
    ld_valid_i = 1; ld_rd_addr_i = 8; ld_data_i = 32'h88;
    cycle();
    ld_rd_addr_i = 9; ld_data_i = 32'h89;
    cycle();
    ld_valid_i = 0;
    settle();
    chk("rst_mid_pend", pending_o, 32'h300);
    rst_i = 1; wb_valid_i = 0;
    settle();
    chk("rst_mid_addr", 32'(rf_rd_addr_o), 32'd0);
    chk("rst_mid_ready", 32'(ld_ready_o), 32'd0);
    cycle();
    rst_i = 0;
    settle();
    chk("rst_mid_clr", pending_o, 32'd0);
    chk("rst_mid_empty", 32'(rf_rd_addr_o), 32'd0);
    cycle();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      rst_i          = ($urandom_range(0, 99) == 0);
      iss_valid_i    = $urandom_range(0, 1);
      iss_rs1_addr_i = 5'($urandom_range(0, 7));
      iss_rs2_addr_i = 5'($urandom_range(0, 7));
      iss_rd_addr_i  = 5'($urandom_range(0, 7));
      iss_is_load_i  = ($urandom_range(0, 2) == 0);
      if (q.size() > 0 && q[0][36:32] == iss_rd_addr_i)
        iss_is_load_i = 0;
      wb_valid_i   = ($urandom_range(0, 3) != 0);
      wb_rd_addr_i = 5'($urandom_range(0, 31));
      wb_data_i    = $urandom;
      ld_valid_i   = $urandom_range(0, 1);
      ld_rd_addr_i = 5'($urandom_range(0, 7));
      ld_data_i    = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
